// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART packet transmitter
// Latches the winning packet, starts the transmitter, waits for done (or watchdog) and acks.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int PKT_WIDTH      = 42,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*PKT_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]             ack,
  output logic                           busy,
  output logic                           tx_start,
  output logic [PKT_WIDTH-1:0]           tx_data,
  input  logic                           tx_done,
  output logic                           timeout_err,
  input  logic                           err_clear
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

  localparam logic [IDX_W:0]   NUM_REQ_L = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam bit               WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     grant_idx;
  logic [CNT_W-1:0]     wdog_cnt;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W:0]       cand;
  logic [PKT_WIDTH-1:0] win_data;

  // Offsets are scanned from farthest to nearest so the closest requester at or after rr_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(off);
      if (cand >= NUM_REQ_L) begin
        cand = cand - NUM_REQ_L;
      end
      if (req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == win_idx) begin
        win_data = req_data[i*PKT_WIDTH +: PKT_WIDTH];
      end
    end
  end

  // Outputs are registered alongside the state so they carry no combinational path from inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      wdog_cnt    <= '0;
      tx_data     <= '0;
      ack         <= '0;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (err_clear) begin
        timeout_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          ack <= '0;
          if (win_found) begin
            grant_idx <= win_idx;
            tx_data   <= win_data;
            tx_start  <= 1'b1;
            busy      <= 1'b1;
            state     <= START;
          end
        end

        START: begin
          tx_start <= 1'b0;
          wdog_cnt <= '0;
          state    <= WAIT;
        end

        WAIT: begin
          if (tx_done) begin
            ack   <= NUM_REQ'(1) << grant_idx;
            state <= ACK;
          end else if (WDOG_EN && (wdog_cnt == CNT_LAST)) begin
            timeout_err <= 1'b1;
            ack         <= NUM_REQ'(1) << grant_idx;
            state       <= ACK;
          end else if (wdog_cnt != {CNT_W{1'b1}}) begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
        end

        ACK: begin
          ack    <= '0;
          busy   <= 1'b0;
          rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
          state  <= IDLE;
        end

        default: begin
          ack      <= '0;
          tx_start <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
// Stimulus pushes expected acks; a negedge monitor pops and compares each ack it sees.
module tb_uart_tx_arbiter;

  localparam int NR = 2;
  localparam int PW = 42;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   req = '0;
  logic [NR*PW-1:0] req_data = '0;
  logic [NR-1:0]   ack;
  logic            busy;
  logic            tx_start;
  logic [PW-1:0]   tx_data;
  logic            tx_done;
  logic            timeout_err;
  logic            err_clear = 1'b0;

  logic            resp_done = 1'b0;
  logic            stray_done = 1'b0;
  int              done_delay = 0;
  int              pend = 0;

  assign tx_done = resp_done | stray_done;

  uart_tx_arbiter #(.NUM_REQ(NR), .PKT_WIDTH(PW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .busy(busy), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .timeout_err(timeout_err), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [PW-1:0] data;
    int          cyc;
    logic        terr;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic rr_chk = 1'b0;
  int   rr_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Transmitter model: done arrives done_delay cycles after tx_start; 0 means never.
  always @(negedge clk) begin
    resp_done = 1'b0;
    if (reset) begin
      pend = 0;
    end else if (tx_start && done_delay > 0) begin
      pend = done_delay;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) resp_done = 1'b1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic [NR-1:0] one;
    if (rr_chk) begin
      check("rr_ptr", 64'(dut.rr_ptr), 64'(rr_exp));
      rr_chk = 1'b0;
    end
    if (ack !== '0) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 64'(ack), 64'(0));
      end else begin
        e = sb.pop_front();
        one = 1;
        check("ack_onehot", 64'(ack), 64'(one << e.idx));
        check("ack_tx_data", 64'(tx_data), 64'(e.data));
        check("ack_cycle", 64'(cyc), 64'(e.cyc));
        check("ack_timeout_err", 64'(timeout_err), 64'(e.terr));
        rr_exp = (e.idx + 1) % NR;
        rr_chk = 1'b1;
      end
    end
  end

  task automatic push(input int idx, input logic [PW-1:0] data, input int c, input logic terr);
    exp_t e;
    e.idx = idx; e.data = data; e.cyc = c; e.terr = terr;
    sb.push_back(e);
  endtask

  initial begin
    int c;
    logic [PW-1:0] d1, da, db, dc, dd, de, df, dg;
    d1 = 42'h20ADEADBEEF;
    da = 42'h1111_2222_333;
    db = 42'h2AAA_5555_444;
    dc = 42'h0C0_FFEE_0042;
    dd = 42'h3FF_1234_5678;
    de = 42'h155_CAFE_F00D;
    df = 42'h0AA_0BAD_BEEF;
    dg = 42'h201_8765_4321;

    tick(3);
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_tx_start", 64'(tx_start), 64'(0));
    check("rst_tx_data", 64'(tx_data), 64'(0));
    check("rst_timeout_err", 64'(timeout_err), 64'(0));
    reset = 1'b0;
    tick(1);

    // Single request, done 5 cycles after tx_start
    c = cyc; req_data[0*PW +: PW] = d1; req = 2'b01; done_delay = 5;
    push(0, d1, c + 7, 1'b0);
    tick(1);
    check("single_tx_start", 64'(tx_start), 64'(1));
    check("single_busy", 64'(busy), 64'(1));
    check("single_tx_data", 64'(tx_data), 64'(d1));
    tick(1);
    check("single_tx_start_pulse", 64'(tx_start), 64'(0));
    tick(5);
    req = 2'b00;
    tick(1);
    check("single_busy_low", 64'(busy), 64'(0));
    check("single_ack_low", 64'(ack), 64'(0));

    // Persistent simultaneous requests from reset
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    c = cyc; req_data[0*PW +: PW] = da; req_data[1*PW +: PW] = db; req = 2'b11; done_delay = 1;
    push(0, da, c + 3, 1'b0);
    push(1, db, c + 7, 1'b0);
    push(0, da, c + 11, 1'b0);
    push(1, db, c + 15, 1'b0);
    tick(5);
    check("rr_tx_start_earliest", 64'(tx_start), 64'(1));
    tick(10);
    req = 2'b00;
    tick(2);

    // Watchdog abort on requester 1
    c = cyc; req_data[1*PW +: PW] = dc; req = 2'b10; done_delay = 0;
    push(1, dc, c + 18, 1'b1);
    tick(17);
    check("wdog_err_before", 64'(timeout_err), 64'(0));
    tick(1);
    req = 2'b00;
    tick(2);
    check("wdog_err_held", 64'(timeout_err), 64'(1));
    check("wdog_idle", 64'(busy), 64'(0));
    tick(1);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("wdog_err_cleared", 64'(timeout_err), 64'(0));
    c = cyc; req_data[0*PW +: PW] = dd; req = 2'b01; done_delay = 3;
    push(0, dd, c + 5, 1'b0);
    tick(5);
    req = 2'b00;
    tick(1);

    // Stray done in IDLE and START; payload change during WAIT
    stray_done = 1'b1;
    tick(1);
    stray_done = 1'b0;
    check("stray_idle_ack", 64'(ack), 64'(0));
    check("stray_idle_busy", 64'(busy), 64'(0));
    tick(1);
    c = cyc; req_data[0*PW +: PW] = de; req = 2'b01; done_delay = 6;
    push(0, de, c + 8, 1'b0);
    tick(1);
    stray_done = 1'b1;
    check("stray_tx_start", 64'(tx_start), 64'(1));
    tick(1);
    stray_done = 1'b0;
    check("stray_start_ack", 64'(ack), 64'(0));
    check("stray_start_busy", 64'(busy), 64'(1));
    tick(1);
    req_data[0*PW +: PW] = df;
    tick(2);
    check("payload_stable", 64'(tx_data), 64'(de));
    tick(3);
    req = 2'b00;
    tick(1);
    check("payload_after_ack", 64'(tx_data), 64'(de));

    // Reset during WAIT, requester 1 keeps req high
    c = cyc; req_data[1*PW +: PW] = dg; req = 2'b10; done_delay = 0;
    tick(4);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_tx_start", 64'(tx_start), 64'(0));
    check("midrst_ack", 64'(ack), 64'(0));
    check("midrst_tx_data", 64'(tx_data), 64'(0));
    check("midrst_timeout_err", 64'(timeout_err), 64'(0));
    done_delay = 2;
    tick(2);
    reset = 1'b0;
    c = cyc;
    push(1, dg, c + 4, 1'b0);
    tick(1);
    check("rearb_tx_start", 64'(tx_start), 64'(1));
    check("rearb_tx_data", 64'(tx_data), 64'(dg));
    tick(3);
    req = 2'b00;
    tick(3);

    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares the single UART packet transmitter between `NUM_REQ` independent requesters, e.g. instruction-memory loader echo, data-memory dump and debug status. Each requester presents a 42-bit packet and holds `req` until it receives a one-cycle `ack`. The arbiter latches the winning packet, pulses the transmitter's start, waits for its done, and acknowledges the requester. A watchdog recovers from a transmitter that never completes.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, range 2–8.
- `PKT_WIDTH`, default 42: packet width. Bit 41 is the target memory, bits 40:32 the address, bits 31:0 the data.
- `TIMEOUT_CYCLES`, default 2000000: maximum `WAIT` duration before abort. A value of 0 disables the watchdog.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req`  in  NUM_REQ  per-requester request level.
- `req_data`  in  NUM_REQ*PKT_WIDTH  requester i's packet at bits [i*PKT_WIDTH +: PKT_WIDTH].
- `ack`  out  NUM_REQ  one-hot, one-cycle completion pulse.
- `busy`  out  1  high in every state except `IDLE`.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `tx_data`  out  PKT_WIDTH  latched packet; stable from `tx_start` until `ack`.
- `tx_done`  in  1  one-cycle completion pulse from the transmitter.
- `timeout_err`  out  1  sticky watchdog flag.
- `err_clear`  in  1  synchronous clear of `timeout_err`.

## Operation
- States: `IDLE`, `START`, `WAIT`, `ACK`.
- **IDLE**
  - If any `req` bit is set, select the winner by searching upward from `rr_ptr`, wrapping modulo `NUM_REQ`.
  - Register the winner in `grant_idx` and latch its slice into `tx_data`. Next state is `START`.
- **START**
  - `tx_start`=1. Clear the watchdog counter. Next state is `WAIT`.
- **WAIT**
  - On `tx_done`=1, go to `ACK`.
  - Otherwise, if `TIMEOUT_CYCLES`≠0 and the counter equals `TIMEOUT_CYCLES`-1, set `timeout_err` and go to `ACK`.
  - Otherwise increment the counter, which saturates and never wraps.
- **ACK**
  - `ack[grant_idx]`=1.
  - Set `rr_ptr` to `grant_idx`+1, wrapping from `NUM_REQ`-1 to 0. Next state is `IDLE`.
- **Requester rules**
  - `req_data` is sampled only in the `IDLE` arbitration cycle. Changes afterwards do not affect `tx_data`.
  - A requester deasserts `req` in the cycle after its `ack`.
  - A `req` still high in the `IDLE` cycle after `ack` is a new packet and is arbitrated normally. It wins only if no other requester between `rr_ptr` and itself is requesting.
  - Dropping `req` before `ack` does not abort the transfer. The `ack` is still pulsed.
- **Ignored inputs**
  - `tx_done` in `IDLE`, `START` or `ACK` is ignored and creates no state change.
- **Error flag**
  - `timeout_err` stays set until `err_clear`.
  - If a timeout and `err_clear` occur in the same cycle, set wins.
- **Widths**
  - `grant_idx` and `rr_ptr` are $clog2(NUM_REQ) bits.
  - The watchdog counter is $clog2(TIMEOUT_CYCLES+1) bits, minimum 1.
- **Reset**
  - `reset` is asynchronous from any state.
  - State returns to `IDLE`; `rr_ptr`, `grant_idx` and the counter go to 0.
  - `tx_data`=0, `ack`=0, `tx_start`=0, `busy`=0, `timeout_err`=0.
  - A transfer in flight is dropped with no `ack`. The requester keeps `req` high and is re-arbitrated after reset.

## Timing
- `ack`, `tx_start` and `busy` are decoded directly from registered state, so they have no combinational path from inputs.
- Cycle sequence, taking `req` seen high in `IDLE` at cycle 0:
  - cycle 1: `START`, `tx_start`=1.
  - cycles 2..: `WAIT`.
  - If `tx_done` is sampled high in cycle D, `ACK` occurs in cycle D+1.
  - `IDLE` occurs in cycle D+2.
  - The earliest next `tx_start` is in cycle D+3.
- Minimum request-to-`ack` latency is 3 cycles, with `tx_done` in cycle 2.
- A timeout with `TIMEOUT_CYCLES`=T gives `ACK` in cycle T+2.
- `tx_data` changes only on the `IDLE` arbitration edge.

## Test plan
- **Single request**
  - Stimulus: `NUM_REQ`=2; `req`=01 with `req_data[41:0]`=0x2_0A_DEADBEEF; `tx_done` returned 5 cycles after `tx_start`.
  - Expected: `tx_start` at cycle 1; `tx_data`=0x20ADEADBEEF; `ack`=01 exactly once, in the cycle after `tx_done`; `busy` low again the following cycle.
- **Simultaneous and persistent requests**
  - Stimulus: `req`=11 from reset, each requester holding `req` after its `ack`.
  - Expected: grants alternate 0,1,0,1; `rr_ptr` sequence 1,0,1,0; no back-to-back grant to the same requester.
- **Watchdog abort**
  - Stimulus: `TIMEOUT_CYCLES`=16 and `tx_done` never asserted.
  - Expected: `ack` at cycle 18; `timeout_err`=1 and held; `err_clear` pulse returns it to 0; the next request proceeds normally.
- **Stray completion and payload stability**
  - Stimulus: `tx_done` pulsed while in `IDLE`, and also in `START`; `req_data` changed during `WAIT`.
  - Expected: no `ack` from the stray pulses; `tx_data` unchanged until `ack`.
- **Reset mid-transfer**
  - Stimulus: assert `reset` during `WAIT`.
  - Expected: all outputs 0 immediately, no `ack`; after release, the still-asserted requester is re-served with `tx_start` one cycle after the first `IDLE` cycle.
